// File: rtl/pm_pkg.sv
// Shared helpers for the packet pacing generator and the receive-side rate monitor.
// Popcount, window byte budget / tolerance limits and a counter-width helper.
package pm_pkg;

    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

    function automatic longint unsigned expected_bytes(
        input longint unsigned bw,
        input longint unsigned win,
        input longint unsigned freq
    );
        return (bw * win) / (64'd8 * freq);
    endfunction

    function automatic longint unsigned low_limit(
        input longint unsigned expv,
        input longint unsigned tol
    );
        return (expv * (64'd100 - tol)) / 64'd100;
    endfunction

    function automatic longint unsigned high_limit(
        input longint unsigned expv,
        input longint unsigned tol
    );
        return (expv * (64'd100 + tol)) / 64'd100;
    endfunction

    // Smallest width able to hold the values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input longint unsigned n);
        int w;
        w = 1;
        for (int i = 1; i < 64; i++) begin
            if ((64'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pm_gap_tracker.sv
// Tracks tlast-to-tlast spacing: saturating gap counter, arm flag and per-window min/max.
// The next-state min/max are exported so the closing window sees a gap landing on its last cycle.
module pm_gap_tracker
    import pm_pkg::*;
#(
    parameter int GAP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_window_restart,
    input  logic                 i_tlast_beat,
    output logic [GAP_WIDTH-1:0] o_min_next,
    output logic [GAP_WIDTH-1:0] o_max_next
);

    logic [GAP_WIDTH-1:0] r_cnt;
    logic [GAP_WIDTH-1:0] r_min;
    logic [GAP_WIDTH-1:0] r_max;
    logic                 r_armed;
    logic [GAP_WIDTH-1:0] w_gap;
    logic                 w_meas;

    assign w_gap  = (&r_cnt) ? '1 : r_cnt + GAP_WIDTH'(1);
    assign w_meas = i_tlast_beat & r_armed;

    assign o_min_next = (w_meas && (w_gap < r_min)) ? w_gap : r_min;
    assign o_max_next = (w_meas && (w_gap > r_max)) ? w_gap : r_max;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_min   <= '1;
            r_max   <= '0;
        end else begin
            if (i_tlast_beat) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (!(&r_cnt)) begin
                r_cnt <= r_cnt + GAP_WIDTH'(1);
            end
            if (i_window_restart) begin
                r_min <= '1;
                r_max <= '0;
            end else begin
                r_min <= o_min_next;
                r_max <= o_max_next;
            end
        end
    end

endmodule

// File: rtl/pm_rate_monitor.sv
// Passive AXI-Stream tap: per-window byte/frame counts, min/max frame spacing
// and bandwidth tolerance flags, published as a one-cycle stats_valid snapshot.
module pm_rate_monitor
    import pm_pkg::*;
#(
    parameter int              DATA_WIDTH    = 64,
    parameter longint unsigned FREQUENCY     = 350000000,
    parameter longint unsigned BANDWIDTH     = 1000000000,
    parameter longint unsigned WINDOW_CYCLES = 350000,
    parameter longint unsigned TOLERANCE_PCT = 5,
    parameter int              CNT_WIDTH     = 32,
    parameter int              GAP_WIDTH     = 16,
    localparam int             KEEP_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    input  logic [KEEP_WIDTH-1:0] mon_tkeep,
    output logic                  stats_valid,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic [GAP_WIDTH-1:0]  min_gap,
    output logic [GAP_WIDTH-1:0]  max_gap,
    output logic                  rate_low,
    output logic                  rate_high
);

    localparam longint unsigned EXPECTED =
        expected_bytes(BANDWIDTH, WINDOW_CYCLES, FREQUENCY);
    localparam longint unsigned LOW_LIMIT  = low_limit(EXPECTED, TOLERANCE_PCT);
    localparam longint unsigned HIGH_LIMIT = high_limit(EXPECTED, TOLERANCE_PCT);
    localparam int              WIN_W      = cnt_width(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 64'd1);

    logic [WIN_W-1:0]     r_win;
    logic [CNT_WIDTH-1:0] r_bytes;
    logic [CNT_WIDTH-1:0] r_frames;
    logic                 r_stats_valid;
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [CNT_WIDTH-1:0] r_byte_count;
    logic [GAP_WIDTH-1:0] r_min_gap;
    logic [GAP_WIDTH-1:0] r_max_gap;
    logic                 r_rate_low;
    logic                 r_rate_high;

    logic                 w_beat;
    logic                 w_last_beat;
    logic                 w_term;
    logic [7:0]           w_pop;
    logic [CNT_WIDTH:0]   w_bsum;
    logic [CNT_WIDTH:0]   w_fsum;
    logic [CNT_WIDTH-1:0] w_bytes_next;
    logic [CNT_WIDTH-1:0] w_frames_next;
    logic [GAP_WIDTH-1:0] w_min_next;
    logic [GAP_WIDTH-1:0] w_max_next;
    logic [GAP_WIDTH-1:0] w_min_rep;

    assign w_beat      = mon_tvalid & mon_tready;
    assign w_last_beat = w_beat & mon_tlast;
    assign w_term      = enable && (r_win == WIN_LAST);
    assign w_pop       = w_beat ? popcount(64'(mon_tkeep)) : 8'd0;

    assign w_bsum = {1'b0, r_bytes} + (CNT_WIDTH + 1)'(w_pop);
    assign w_fsum = {1'b0, r_frames} + (CNT_WIDTH + 1)'(w_last_beat);
    assign w_bytes_next  = w_bsum[CNT_WIDTH] ? '1 : w_bsum[CNT_WIDTH-1:0];
    assign w_frames_next = w_fsum[CNT_WIDTH] ? '1 : w_fsum[CNT_WIDTH-1:0];

    // A window with no measured gap reports 0 for both extremes.
    assign w_min_rep = (w_max_next == '0) ? '0 : w_min_next;

    pm_gap_tracker #(
        .GAP_WIDTH(GAP_WIDTH)
    ) u_gap (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (~enable),
        .i_window_restart(w_term),
        .i_tlast_beat    (w_last_beat),
        .o_min_next      (w_min_next),
        .o_max_next      (w_max_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win         <= '0;
            r_bytes       <= '0;
            r_frames      <= '0;
            r_stats_valid <= 1'b0;
            r_frame_count <= '0;
            r_byte_count  <= '0;
            r_min_gap     <= '0;
            r_max_gap     <= '0;
            r_rate_low    <= 1'b0;
            r_rate_high   <= 1'b0;
        end else if (!enable) begin
            r_win         <= '0;
            r_bytes       <= '0;
            r_frames      <= '0;
            r_stats_valid <= 1'b0;
        end else begin
            r_stats_valid <= w_term;
            if (w_term) begin
                r_win         <= '0;
                r_bytes       <= '0;
                r_frames      <= '0;
                r_frame_count <= w_frames_next;
                r_byte_count  <= w_bytes_next;
                r_min_gap     <= w_min_rep;
                r_max_gap     <= w_max_next;
                r_rate_low    <= 64'(w_bytes_next) < LOW_LIMIT;
                r_rate_high   <= 64'(w_bytes_next) > HIGH_LIMIT;
            end else begin
                r_win    <= r_win + WIN_W'(1);
                r_bytes  <= w_bytes_next;
                r_frames <= w_frames_next;
            end
        end
    end

    assign stats_valid = r_stats_valid;
    assign frame_count = r_frame_count;
    assign byte_count  = r_byte_count;
    assign min_gap     = r_min_gap;
    assign max_gap     = r_max_gap;
    assign rate_low    = r_rate_low;
    assign rate_high   = r_rate_high;

endmodule
